// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, FSM encodings and byte-merge helper shared by the CLINT.
package clint_pkg;
    localparam logic [15:0] MSIP_OFF       = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF   = 16'h4000;
    localparam logic [15:0] MTIME_OFF      = 16'hBFF8;
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [1:0]  ST_IDLE        = 2'd0;
    localparam logic [1:0]  ST_ACK         = 2'd1;
    localparam logic [1:0]  ST_RELEASE     = 2'd2;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v, input logic [63:0] new_v,
                                                input logic [7:0] be);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: emits a one-cycle tick every CLOCK_CYCLES clocks (constant 1 when CLOCK_CYCLES = 1).
module clint_prescaler #(
    parameter int CLOCK_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CW = CLOCK_CYCLES > 1 ? $clog2(CLOCK_CYCLES) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = r_cnt == CW'(CLOCK_CYCLES - 1);

    always_ff @(posedge clock) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/clint.sv
// clint: core-local interruptor with msip/mtimecmp/mtime registers and prescaled mtime counter.
// Defining CLINT_TIMER_IRQ_EN adds a registered timer_irq output (mtime >= mtimecmp).
module clint
    import clint_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int CLOCK_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [15:0]            addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   ack,
    output logic [DATA_SIZE-1:0]   msip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
`ifdef CLINT_TIMER_IRQ_EN
    ,
    output logic                   timer_irq
`endif
);
    logic [1:0]           r_state;
    logic                 r_msip;
    logic [63:0]          r_mtime;
    logic [63:0]          r_mtimecmp;
    logic [DATA_SIZE-1:0] r_rd_data;
    logic                 w_tick;
    logic                 w_req;
    logic                 w_wr;
    logic                 w_hi;
    logic [15:0]          w_word;
    logic                 w_sel_msip;
    logic                 w_sel_cmp;
    logic                 w_sel_time;
    logic [63:0]          w_wd;
    logic [7:0]           w_be;
    logic [63:0]          w_rd64;

    clint_prescaler #(.CLOCK_CYCLES(CLOCK_CYCLES)) u_prescaler (
        .clock(clock),
        .reset(reset),
        .tick (w_tick)
    );

    // Byte-lane bits of the offset are dropped; on a 32-bit bus addr[2] selects the high word.
    assign w_word     = addr & ~16'(DATA_SIZE / 8 - 1);
    assign w_hi       = (DATA_SIZE == 32) && addr[2];
    assign w_sel_msip = w_word == MSIP_OFF;
    assign w_sel_cmp  = (w_word & ~16'h0004) == MTIMECMP_OFF;
    assign w_sel_time = (w_word & ~16'h0004) == MTIME_OFF;
    assign w_req      = (r_state == ST_IDLE) && (rd_en || wr_en);
    assign w_wr       = w_req && wr_en;
    assign w_wd       = 64'(wr_data) << (w_hi ? 32 : 0);
    assign w_be       = 8'(byte_en) << (w_hi ? 4 : 0);
    assign w_rd64     = w_sel_msip ? 64'(r_msip) : w_sel_cmp ? r_mtimecmp : w_sel_time ? r_mtime : 64'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_msip     <= 1'b0;
            r_mtime    <= 64'h0;
            r_mtimecmp <= MTIMECMP_RESET;
            r_rd_data  <= '0;
        end else begin
            r_state <= r_state == ST_IDLE ? (w_req ? ST_ACK : ST_IDLE) :
                       r_state == ST_ACK  ? ST_RELEASE :
                       (rd_en || wr_en)   ? ST_RELEASE : ST_IDLE;
            if (w_req) r_rd_data <= wr_en ? '0 : DATA_SIZE'(w_rd64 >> (w_hi ? 32 : 0));
            if (w_wr && w_sel_msip && byte_en[0]) r_msip <= wr_data[0];
            if (w_wr && w_sel_cmp) r_mtimecmp <= merge_bytes(r_mtimecmp, w_wd, w_be);
            // A bus write beats the tick; unwritten bytes keep their pre-increment value.
            if (w_wr && w_sel_time) r_mtime <= merge_bytes(r_mtime, w_wd, w_be);
            else if (w_tick)        r_mtime <= r_mtime + 64'd1;
        end
    end

`ifdef CLINT_TIMER_IRQ_EN
    logic r_irq;

    always_ff @(posedge clock) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= r_mtime >= r_mtimecmp;
    end

    assign timer_irq = r_irq;
`endif

    assign rd_data  = r_rd_data;
    assign ack      = r_state == ST_ACK;
    assign msip     = DATA_SIZE'(r_msip);
    assign mtime    = r_mtime;
    assign mtimecmp = r_mtimecmp;
endmodule

// File: tb/tb_clint.sv
// tb_clint: directed checks of the CLINT on a 32-bit bus, with a second instance for prescaler timing.
module tb_clint;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  byte_en = 4'h0;
    logic [31:0] rd_data, rd4, msip, msip4;
    logic        ack, ack4;
    logic [63:0] mtime, mtimecmp, mtime4, cmp4;
`ifdef CLINT_TIMER_IRQ_EN
    logic        timer_irq, irq4;
`endif
    int          n_chk = 0;
    int          n_err = 0;
    int          acks;
    logic [31:0] t_rd;
    logic [63:0] t_mt0, t_mt1;

    always #5 clock = ~clock;

    clint #(.DATA_SIZE(32), .CLOCK_CYCLES(1)) u_dut (
        .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .byte_en(byte_en), .rd_data(rd_data), .ack(ack),
        .msip(msip), .mtime(mtime), .mtimecmp(mtimecmp)
`ifdef CLINT_TIMER_IRQ_EN
        , .timer_irq(timer_irq)
`endif
    );

    clint #(.DATA_SIZE(32), .CLOCK_CYCLES(4)) u_dut4 (
        .clock(clock), .reset(reset), .rd_en(1'b0), .wr_en(1'b0), .addr(16'h0),
        .wr_data(32'h0), .byte_en(4'h0), .rd_data(rd4), .ack(ack4),
        .msip(msip4), .mtime(mtime4), .mtimecmp(cmp4)
`ifdef CLINT_TIMER_IRQ_EN
        , .timer_irq(irq4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
    task automatic bus(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        int lat;
        rd_en = rd; wr_en = wr; addr = a; wr_data = d; byte_en = be;
        for (lat = 1; lat <= 5; lat++) begin
            @(negedge clock);
            if (ack) break;
        end
        check("ack_latency", 64'(lat), 64'd1);
        t_rd  = rd_data;
        t_mt0 = mtime;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clock);
        t_mt1 = mtime;
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        check("rst_mtime", mtime, 64'h0);
        check("rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_msip", 64'(msip), 64'h0);
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_mtime4", mtime4, 64'h0);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("presc4_mtime", mtime4, 64'd3);
        check("presc1_mtime", mtime, 64'd12);

        bus(1'b0, 1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
        check("msip_write", 64'(msip), 64'h1);
        bus(1'b1, 1'b0, 16'h0000, 32'h0, 4'h0);
        check("msip_read", 64'(t_rd), 64'h1);

        rd_en = 1'b1; addr = 16'h0000; acks = 0;
        repeat (5) begin
            @(negedge clock);
            if (ack) acks++;
        end
        rd_en = 1'b0;
        repeat (2) @(negedge clock);
        check("held_rd_one_ack", 64'(acks), 64'd1);

        bus(1'b0, 1'b1, 16'h4004, 32'h0, 4'hF);
        bus(1'b0, 1'b1, 16'h4000, 32'h10, 4'hF);
        check("mtimecmp_32", mtimecmp, 64'h10);
        bus(1'b1, 1'b0, 16'h4000, 32'h0, 4'h0);
        check("mtimecmp_rd_lo", 64'(t_rd), 64'h10);
        bus(1'b1, 1'b0, 16'h1234, 32'h0, 4'h0);
        check("unmapped_rd", 64'(t_rd), 64'h0);
        bus(1'b0, 1'b1, 16'h1234, 32'hFFFF_FFFF, 4'hF);
        check("unmapped_wr_cmp", mtimecmp, 64'h10);
        check("unmapped_wr_msip", 64'(msip), 64'h1);

`ifdef CLINT_TIMER_IRQ_EN
        check("irq_high", 64'(timer_irq), 64'h1);
        bus(1'b0, 1'b1, 16'hBFF8, 32'h0, 4'hF);
        check("irq_low_after_clear", 64'(timer_irq), 64'h0);
        for (int i = 0; i < 40 && mtime != 64'd16; i++) @(negedge clock);
        check("irq_wait_mtime16", mtime, 64'd16);
        check("irq_still_low", 64'(timer_irq), 64'h0);
        @(negedge clock);
        check("irq_rise", 64'(timer_irq), 64'h1);
`endif

        bus(1'b1, 1'b1, 16'h4000, 32'h20, 4'hF);
        check("rdwr_rd_data", 64'(t_rd), 64'h0);
        check("rdwr_as_write", mtimecmp, 64'h20);

        bus(1'b0, 1'b1, 16'hBFFC, 32'h0, 4'hF);
        bus(1'b0, 1'b1, 16'hBFF8, 32'h0000_01FC, 4'hF);
        check("mtime_lo_write", t_mt0, 64'h1FC);
        bus(1'b0, 1'b1, 16'hBFF8, 32'h0000_0100, 4'b0001);
        check("write_vs_tick", t_mt0, 64'h100);
        check("write_vs_tick_next", t_mt1, 64'h101);

        bus(1'b0, 1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        bus(1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        check("wrap_max", t_mt0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_zero", t_mt1, 64'h0);

        rd_en = 1'b1; addr = 16'h4000;
        @(negedge clock);
        check("mid_rst_ack_pre", 64'(ack), 64'h1);
        check("mid_rst_rd_pre", 64'(rd_data), 64'h20);
        reset = 1'b1; rd_en = 1'b0;
        @(negedge clock);
        check("mid_rst_ack", 64'(ack), 64'h0);
        check("mid_rst_rd_data", 64'(rd_data), 64'h0);
        check("mid_rst_mtime", mtime, 64'h0);
        check("mid_rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mid_rst_msip", 64'(msip), 64'h0);
        reset = 1'b0;
        bus(1'b1, 1'b0, 16'h4000, 32'h0, 4'h0);
        check("post_rst_rd", 64'(t_rd), 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
